// File: rtl/core_pipe_mem_req_if.sv
// Data memory request bus between the execute-stage LSU and the memory port.
// The master side drives the request; the slave side answers with grant/error.
interface core_pipe_mem_req_if #(
  parameter int MEM_ADDR_W = 64
);
  logic                  req;
  logic [MEM_ADDR_W-1:0] addr;
  logic                  wen;
  logic [7:0]            strb;
  logic [63:0]           wdata;
  logic                  gnt;
  logic                  err;

  modport master (output req, addr, wen, strb, wdata, input gnt, err);
  modport slave  (input req, addr, wen, strb, wdata, output gnt, err);
endinterface

// File: rtl/core_pipe_mem_req.sv
// Memory-request half of the execute stage: issues data memory requests and hands results to writeback.
// CORE_LSU_MISALIGN_TRAP_EN: misaligned LSU ops trap; otherwise their low address bits are forced to zero.
module core_pipe_mem_req #(
  parameter int XLEN       = 64,
  parameter int MEM_ADDR_W = 64,
  parameter int LSU_OP_W   = 7
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                s2_valid,
  output logic                s2_ready,
  input  logic [LSU_OP_W-1:0] s2_lsu_op,
  input  logic [XLEN-1:0]     s2_addr,
  input  logic [XLEN-1:0]     s2_wdata,
  output logic                s3_valid,
  input  logic                s3_ready,
  output logic [LSU_OP_W-1:0] s3_lsu_op,
  output logic [XLEN-1:0]     s3_wdata,
  output logic                s3_trap,
  output logic [5:0]          s3_trap_cause,
  input  logic                flush,
  core_pipe_mem_req_if.master dmem
);
  localparam int XL = XLEN - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD, ST_REQ_KILL} state_t;

  state_t                state_r, state_s, load_state_s;
  logic                  accept_s, gnt_s, is_load_s, is_store_s, is_lsu_s, mis_trap_s;
  logic [7:0]            size_mask_s;
  logic [2:0]            low_mask_s;
  logic [XL:0]           eff_addr_s;
  logic [63:0]           st_data_s;
  logic [LSU_OP_W-1:0]   s3_lsu_op_r;
  logic [XL:0]           s3_wdata_r;
  logic                  s3_trap_r;
  logic [5:0]            s3_trap_cause_r;
  logic                  dmem_req_r, dmem_wen_r;
  logic [MEM_ADDR_W-1:0] dmem_addr_r;
  logic [7:0]            dmem_strb_r;
  logic [63:0]           dmem_wdata_r;

  assign is_load_s  = s2_lsu_op[0];
  assign is_store_s = s2_lsu_op[1];
  assign is_lsu_s   = is_load_s | is_store_s;
  assign st_data_s  = 64'(s2_wdata);
  assign gnt_s      = dmem.gnt;

  // Access size decode: byte-lane mask and the address bits that must be zero.
  always_comb begin
    size_mask_s = 8'h00;
    low_mask_s  = 3'b000;
    if (s2_lsu_op[5]) begin
      size_mask_s = 8'hFF;
      low_mask_s  = 3'b111;
    end else if (s2_lsu_op[4]) begin
      size_mask_s = 8'h0F;
      low_mask_s  = 3'b011;
    end else if (s2_lsu_op[3]) begin
      size_mask_s = 8'h03;
      low_mask_s  = 3'b001;
    end else if (s2_lsu_op[2]) begin
      size_mask_s = 8'h01;
      low_mask_s  = 3'b000;
    end else begin
      size_mask_s = 8'h00;
      low_mask_s  = 3'b000;
    end
  end

`ifdef CORE_LSU_MISALIGN_TRAP_EN
  logic misalign_s;
  assign misalign_s = |(s2_addr[2:0] & low_mask_s);
  assign mis_trap_s = is_lsu_s & misalign_s;
  assign eff_addr_s = s2_addr;
`else
  assign mis_trap_s = 1'b0;
  assign eff_addr_s = {s2_addr[XL:3], s2_addr[2:0] & ~low_mask_s};
`endif

  assign s2_ready     = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && s3_ready);
  assign accept_s     = s2_valid && s2_ready && !flush;
  assign load_state_s = (is_lsu_s && !mis_trap_s) ? ST_REQ : ST_HOLD;

  // State register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a flush mid-request waits out the grant in ST_REQ_KILL.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush)         state_s = ST_IDLE;
        else if (accept_s) state_s = load_state_s;
        else               state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (flush)      state_s = gnt_s ? ST_IDLE : ST_REQ_KILL;
        else if (gnt_s) state_s = ST_HOLD;
        else            state_s = ST_REQ;
      end
      ST_HOLD: begin
        if (flush)         state_s = ST_IDLE;
        else if (accept_s) state_s = load_state_s;
        else if (s3_ready) state_s = ST_IDLE;
        else               state_s = ST_HOLD;
      end
      ST_REQ_KILL: begin
        if (gnt_s) state_s = ST_IDLE;
        else       state_s = ST_REQ_KILL;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Registered request fields and writeback payload.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      s3_lsu_op_r     <= {LSU_OP_W{1'b0}};
      s3_wdata_r      <= {XLEN{1'b0}};
      s3_trap_r       <= 1'b0;
      s3_trap_cause_r <= 6'd0;
      dmem_req_r      <= 1'b0;
      dmem_wen_r      <= 1'b0;
      dmem_addr_r     <= {MEM_ADDR_W{1'b0}};
      dmem_strb_r     <= 8'h00;
      dmem_wdata_r    <= 64'h0;
    end else if (accept_s) begin
      s3_lsu_op_r     <= s2_lsu_op;
      s3_wdata_r      <= is_lsu_s ? eff_addr_s : s2_wdata;
      s3_trap_r       <= mis_trap_s;
      s3_trap_cause_r <= mis_trap_s ? (is_load_s ? 6'd4 : 6'd6) : 6'd0;
      if (is_lsu_s && !mis_trap_s) begin
        dmem_req_r   <= 1'b1;
        dmem_wen_r   <= is_store_s;
        dmem_addr_r  <= {eff_addr_s[MEM_ADDR_W-1:3], 3'b000};
        dmem_strb_r  <= 8'(size_mask_s << eff_addr_s[2:0]);
        dmem_wdata_r <= st_data_s << {eff_addr_s[2:0], 3'b000};
      end else begin
        dmem_req_r   <= 1'b0;
        dmem_wen_r   <= 1'b0;
        dmem_addr_r  <= {MEM_ADDR_W{1'b0}};
        dmem_strb_r  <= 8'h00;
        dmem_wdata_r <= 64'h0;
      end
    end else if (dmem_req_r && gnt_s) begin
      dmem_req_r   <= 1'b0;
      dmem_wen_r   <= 1'b0;
      dmem_addr_r  <= {MEM_ADDR_W{1'b0}};
      dmem_strb_r  <= 8'h00;
      dmem_wdata_r <= 64'h0;
      if ((state_r == ST_REQ) && !flush) begin
        s3_trap_r       <= dmem.err;
        s3_trap_cause_r <= dmem.err ? (s3_lsu_op_r[0] ? 6'd5 : 6'd7) : 6'd0;
      end else begin
        s3_trap_r       <= 1'b0;
        s3_trap_cause_r <= 6'd0;
      end
    end else if (state_s == ST_IDLE) begin
      s3_trap_r       <= 1'b0;
      s3_trap_cause_r <= 6'd0;
    end
  end

  assign s3_valid      = (state_r == ST_HOLD);
  assign s3_lsu_op     = s3_lsu_op_r;
  assign s3_wdata      = s3_wdata_r;
  assign s3_trap       = s3_trap_r;
  assign s3_trap_cause = s3_trap_cause_r;
  assign dmem.req      = dmem_req_r;
  assign dmem.addr     = dmem_addr_r;
  assign dmem.wen      = dmem_wen_r;
  assign dmem.strb     = dmem_strb_r;
  assign dmem.wdata    = dmem_wdata_r;
endmodule

// File: tb/tb_core_pipe_mem_req.sv
// Directed vector bench for core_pipe_mem_req: a table of LSU/pass-through ops plus
// hand-written back-to-back, stall, flush and dropped-accept sequences.
module tb_core_pipe_mem_req;
  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        s2_valid, s2_ready, s3_valid, s3_ready, s3_trap, flush;
  logic [6:0]  s2_lsu_op, s3_lsu_op;
  logic [63:0] s2_addr, s2_wdata, s3_wdata;
  logic [5:0]  s3_trap_cause;
  int          total = 0;
  int          bad = 0;

  core_pipe_mem_req_if #(.MEM_ADDR_W(64)) dmem_if ();

  core_pipe_mem_req dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_lsu_op(s2_lsu_op),
    .s2_addr(s2_addr), .s2_wdata(s2_wdata),
    .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_lsu_op(s3_lsu_op),
    .s3_wdata(s3_wdata), .s3_trap(s3_trap), .s3_trap_cause(s3_trap_cause),
    .flush(flush), .dmem(dmem_if)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [6:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          dly;
    logic        err;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic        exp_wen;
    logic [63:0] exp_dwdata;
    logic [63:0] exp_s3wdata;
    logic        exp_trap;
    logic [5:0]  exp_cause;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cnt;
    @(negedge g_clk);
    s2_valid = 1'b1; s2_lsu_op = v.op; s2_addr = v.addr; s2_wdata = v.wdata;
    chk($sformatf("v%0d_s2_ready", idx), 64'(s2_ready), 64'd1);
    @(posedge g_clk);
    @(negedge g_clk);
    s2_valid = 1'b0; s2_lsu_op = 7'd0;
    chk($sformatf("v%0d_req", idx), 64'(dmem_if.req), 64'(v.exp_req));
    if (v.exp_req) begin
      chk($sformatf("v%0d_addr", idx), dmem_if.addr, v.exp_addr);
      chk($sformatf("v%0d_strb", idx), 64'(dmem_if.strb), 64'(v.exp_strb));
      chk($sformatf("v%0d_wen", idx), 64'(dmem_if.wen), 64'(v.exp_wen));
      chk($sformatf("v%0d_dwdata", idx), dmem_if.wdata, v.exp_dwdata);
      chk($sformatf("v%0d_s3v_during_req", idx), 64'(s3_valid), 64'd0);
      cnt = 0;
      while (dmem_if.req && cnt < 20) begin
        cnt++;
        if (cnt == v.dly) begin
          dmem_if.gnt = 1'b1; dmem_if.err = v.err;
        end
        @(posedge g_clk);
        @(negedge g_clk);
        dmem_if.gnt = 1'b0; dmem_if.err = 1'b0;
      end
      chk($sformatf("v%0d_req_cycles", idx), 64'(cnt), 64'(v.dly));
      chk($sformatf("v%0d_strb_idle", idx), 64'(dmem_if.strb), 64'd0);
    end
    chk($sformatf("v%0d_s3_valid", idx), 64'(s3_valid), 64'd1);
    chk($sformatf("v%0d_s3_wdata", idx), s3_wdata, v.exp_s3wdata);
    chk($sformatf("v%0d_s3_trap", idx), 64'(s3_trap), 64'(v.exp_trap));
    chk($sformatf("v%0d_cause", idx), 64'(s3_trap_cause), 64'(v.exp_cause));
    chk($sformatf("v%0d_s3_op", idx), 64'(s3_lsu_op), 64'(v.op));
    @(posedge g_clk);
    @(negedge g_clk);
    chk($sformatf("v%0d_s3_valid_off", idx), 64'(s3_valid), 64'd0);
  endtask

  initial begin
    g_resetn = 1'b0; s2_valid = 1'b0; s2_lsu_op = 7'd0; s2_addr = 64'd0; s2_wdata = 64'd0;
    s3_ready = 1'b1; flush = 1'b0; dmem_if.gnt = 1'b0; dmem_if.err = 1'b0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
    chk("rst_s3_valid", 64'(s3_valid), 64'd0);
    chk("rst_req", 64'(dmem_if.req), 64'd0);
    chk("rst_wen", 64'(dmem_if.wen), 64'd0);
    chk("rst_strb", 64'(dmem_if.strb), 64'd0);
    chk("rst_s3_wdata", s3_wdata, 64'd0);
    chk("rst_trap", 64'({s3_trap, s3_trap_cause}), 64'd0);
    chk("rst_s2_ready", 64'(s2_ready), 64'd1);

    // op bits {SEXT,DOUBLE,WORD,HALF,BYTE,STORE,LOAD}
    vecs[0] = '{7'b0100001, 64'h1008, 64'h0, 3, 1'b0, 1'b1, 64'h1008, 8'hFF, 1'b0, 64'h0, 64'h1008, 1'b0, 6'd0};
    vecs[1] = '{7'b0000110, 64'h2005, 64'hAB, 1, 1'b0, 1'b1, 64'h2000, 8'h20, 1'b1, 64'h0000_AB00_0000_0000, 64'h2005, 1'b0, 6'd0};
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    vecs[2] = '{7'b0010001, 64'h3002, 64'h0, 1, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 64'h3002, 1'b1, 6'd4};
    vecs[5] = '{7'b0001010, 64'h6003, 64'hBEEF, 1, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 64'h6003, 1'b1, 6'd6};
`else
    vecs[2] = '{7'b0010001, 64'h3002, 64'h0, 1, 1'b0, 1'b1, 64'h3000, 8'h0F, 1'b0, 64'h0, 64'h3000, 1'b0, 6'd0};
    vecs[5] = '{7'b0001010, 64'h6003, 64'hBEEF, 1, 1'b0, 1'b1, 64'h6000, 8'h0C, 1'b1, 64'h0000_0000_BEEF_0000, 64'h6002, 1'b0, 6'd0};
`endif
    vecs[3] = '{7'b0100010, 64'h4000, 64'h1122_3344_5566_7788, 2, 1'b1, 1'b1, 64'h4000, 8'hFF, 1'b1, 64'h1122_3344_5566_7788, 64'h4000, 1'b1, 6'd7};
    vecs[4] = '{7'b0001001, 64'h5006, 64'h0, 1, 1'b1, 1'b1, 64'h5000, 8'hC0, 1'b0, 64'h0, 64'h5006, 1'b1, 6'd5};
    vecs[6] = '{7'b0000000, 64'h9999, 64'hDEAD_BEEF, 0, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 64'hDEAD_BEEF, 1'b0, 6'd0};
    vecs[7] = '{7'b0010010, 64'h7004, 64'h1234_5678, 2, 1'b0, 1'b1, 64'h7000, 8'hF0, 1'b1, 64'h1234_5678_0000_0000, 64'h7004, 1'b0, 6'd0};

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-to-back pass-through ops with s3_ready held high.
    @(negedge g_clk);
    s2_valid = 1'b1; s2_lsu_op = 7'd0; s2_wdata = 64'hA1;
    @(posedge g_clk);
    @(negedge g_clk);
    chk("b2b_v1", 64'(s3_valid), 64'd1);
    chk("b2b_d1", s3_wdata, 64'hA1);
    chk("b2b_ready", 64'(s2_ready), 64'd1);
    s2_wdata = 64'hB2;
    @(posedge g_clk);
    @(negedge g_clk);
    s2_valid = 1'b0;
    chk("b2b_v2", 64'(s3_valid), 64'd1);
    chk("b2b_d2", s3_wdata, 64'hB2);
    @(posedge g_clk);
    @(negedge g_clk);
    chk("b2b_idle", 64'(s3_valid), 64'd0);

    // Writeback stall keeps the result and blocks new ops.
    s2_valid = 1'b1; s2_wdata = 64'h55; s3_ready = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    s2_valid = 1'b0;
    chk("stall_ready", 64'(s2_ready), 64'd0);
    @(posedge g_clk);
    @(negedge g_clk);
    chk("stall_valid", 64'(s3_valid), 64'd1);
    chk("stall_data", s3_wdata, 64'h55);
    s3_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    chk("stall_release", 64'(s3_valid), 64'd0);

    // Accept in the same cycle as flush is dropped.
    s2_valid = 1'b1; s2_wdata = 64'h77; flush = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    s2_valid = 1'b0; flush = 1'b0;
    chk("flush_drop", 64'(s3_valid), 64'd0);

    // Flush in REQ: request held until grant, response discarded.
    s2_valid = 1'b1; s2_lsu_op = 7'b0100001; s2_addr = 64'h8000;
    @(posedge g_clk);
    @(negedge g_clk);
    s2_valid = 1'b0; s2_lsu_op = 7'd0;
    chk("fl_req", 64'(dmem_if.req), 64'd1);
    flush = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b0;
    chk("fl_req_held", 64'(dmem_if.req), 64'd1);
    chk("fl_ready0", 64'(s2_ready), 64'd0);
    chk("fl_s3v0", 64'(s3_valid), 64'd0);
    @(posedge g_clk);
    @(negedge g_clk);
    chk("fl_req_held2", 64'(dmem_if.req), 64'd1);
    chk("fl_ready1", 64'(s2_ready), 64'd0);
    dmem_if.gnt = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    dmem_if.gnt = 1'b0;
    chk("fl_req_drop", 64'(dmem_if.req), 64'd0);
    chk("fl_s3v1", 64'(s3_valid), 64'd0);
    chk("fl_ready_back", 64'(s2_ready), 64'd1);
    @(posedge g_clk);
    @(negedge g_clk);
    chk("fl_s3v2", 64'(s3_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
